add_sched: RTL

ADD_SCHED -- requirements
Module: add_sched

---
 rtl/add_sched_pkg.sv | 17 +
 rtl/add_sched_pipe.sv | 74 +++++++
 rtl/add_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/add_sched_pkg.sv
// add_sched shared types: FSM encoding, default requester count,
// tag width helper.
package add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_sched_pipe.sv
// Two-stage registered adder; hold freezes both stages.
// Optional saturation: define ADD_SCHED_SAT_EN.
module add_sched_pipe
  import add_sched_pkg::*;
#(
  parameter int width = 3,
  parameter int TW    = 2
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             in_vld,
  input  logic [width:0]   in_da,
  input  logic [width:0]   in_db,
  input  logic [TW-1:0]    in_tag,
  output logic             s1_vld,
  output logic             out_vld,
  output logic [width:0]   out_q,
  output logic             out_cout,
  output logic [TW-1:0]    out_tag
);

  logic [width:0]   s1_da;
  logic [width:0]   s1_db;
  logic [TW-1:0]    s1_tag;
  logic [width+1:0] full;
  logic [width:0]   q_nx;

  // Full-width sum of the stage-1 operands, optional clamp on carry
  always_comb begin
    full = {1'b0, s1_da} + {1'b0, s1_db};
    q_nx = full[width:0];
`ifdef ADD_SCHED_SAT_EN
    if (full[width+1])
      q_nx = '1;
`else
`endif
  end

  // Stage 1: capture operands and tag of the granted request
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_da  <= '0;
      s1_db  <= '0;
      s1_tag <= '0;
    end else if (!hold) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_da  <= in_da;
        s1_db  <= in_db;
        s1_tag <= in_tag;
      end
    end
  end

  // Stage 2: capture sum, carry and tag
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_q    <= '0;
      out_cout <= 1'b0;
      out_tag  <= '0;
    end else if (!hold) begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_q    <= q_nx;
        out_cout <= full[width+1];
        out_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one pipelined adder among NREQ.
// Optional saturation: define ADD_SCHED_SAT_EN.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int width = 3,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                        CLK,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*(width+1)-1:0]   req_da,
  input  logic [NREQ*(width+1)-1:0]   req_db,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [width:0]              res_q,
  output logic                        res_cout,
  output logic [tag_w(NREQ)-1:0]      res_tag
);

  localparam int DW = width + 1;
  localparam int TW = tag_w(NREQ);

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   ptr;
  logic [TW-1:0]   gidx;
  logic [NREQ-1:0] gnt;
  logic [DW-1:0]   sel_da;
  logic [DW-1:0]   sel_db;
  logic            hold;
  logic            accept;
  logic            found;
  logic            s1_vld;

  assign hold      = res_valid & ~res_ready;
  assign req_ready = gnt;
  assign accept    = |gnt;

  // Round-robin pick starting at ptr; nothing granted while stalled
  always_comb begin
    gnt    = '0;
    gidx   = '0;
    sel_da = '0;
    sel_db = '0;
    found  = 1'b0;
    if (!hold && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int j = 0; j < NREQ; j++) begin
          if (!found && req_valid[j] &&
              ((int'(ptr) + k) % NREQ) == j) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            gidx   = TW'(j);
            sel_da = req_da[j*DW +: DW];
            sel_db = req_db[j*DW +: DW];
          end
        end
      end
    end
  end

  // Pointer moves past the last grant; untouched without a grant
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (accept)
      ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + TW'(1);
  end

  // FSM state register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = RUN;
      RUN:
        if (hold)
          state_nx = STALL;
        else if (!s1_vld && !res_valid && !accept)
          state_nx = IDLE;
      STALL:
        if (res_ready)
          state_nx = RUN;
      default:
        state_nx = IDLE;
    endcase
  end

  add_sched_pipe #(
    .width (width),
    .TW    (TW)
  ) u_pipe (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .hold     (hold),
    .in_vld   (accept),
    .in_da    (sel_da),
    .in_db    (sel_db),
    .in_tag   (gidx),
    .s1_vld   (s1_vld),
    .out_vld  (res_valid),
    .out_q    (res_q),
    .out_cout (res_cout),
    .out_tag  (res_tag)
  );

endmodule
